// File: rtl/game_sequencer_pkg.sv
// Shared game-flow definitions: phase and result encodings, defaults,
// and the constant-width helpers used by the sequencer and draw logic.
package game_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SERVE = 3'd2,
      ST_PLAY  = 3'd3,
      ST_LOST  = 3'd4,
      ST_CLEAR = 3'd5,
      ST_OVER  = 3'd6,
      ST_WIN   = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_WIN  = 2'b01,
      RES_LOSE = 2'b10
   } result_e;

   localparam int DEF_INIT_HP       = 3;
   localparam int DEF_HP_W          = 6;
   localparam int DEF_LEVEL_NUM     = 4;
   localparam int DEF_SERVE_FRAMES  = 60;
   localparam int DEF_BANNER_FRAMES = 120;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Game-flow bundle: control inputs from buttons/datapath toward the
// sequencer and the phase/score outputs back to the game datapath.
interface game_sequencer_if #(
   parameter int LEVEL_W = 2,
   parameter int HP_W    = 6
);
   logic               frame_tick;
   logic               start;
   logic               level_ready;
   logic               ball_lost;
   logic               all_cleared;
   logic [2:0]         state;
   logic               run;
   logic               serve;
   logic               load_level;
   logic [LEVEL_W-1:0] level;
   logic [HP_W-1:0]    hp;
   logic [1:0]         result;

   modport master (
      output frame_tick, start, level_ready, ball_lost, all_cleared,
      input  state, run, serve, load_level, level, hp, result
   );

   modport slave (
      input  frame_tick, start, level_ready, ball_lost, all_cleared,
      output state, run, serve, load_level, level, hp, result
   );
endinterface

// File: rtl/game_sequencer_frame_timer.sv
// Frame-tick counter with synchronous clear and a terminal-count flag;
// the limit switches between the serve wait and the banner hold.
module game_sequencer_frame_timer #(
   parameter int SERVE_FRAMES  = 60,
   parameter int BANNER_FRAMES = 120,
   parameter int CNT_W         = 7
) (
   input  logic clock,
   input  logic reset,
   input  logic tick,
   input  logic clr,
   input  logic sel_banner,
   output logic done
);
   localparam logic [CNT_W-1:0] SERVE_LIM  = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0] BANNER_LIM = CNT_W'(BANNER_FRAMES);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [CNT_W-1:0] limit;

   assign limit = sel_banner ? BANNER_LIM : SERVE_LIM;
   assign done  = (cnt_q == limit);

   // Holding at the limit keeps done stable until the phase is left.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (tick && !done)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/game_sequencer.sv
// Arkanoid game-flow controller: attract, load, serve, play, banners
// and end-of-game, owning hit points, level index and win/lose result.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int INIT_HP       = DEF_INIT_HP,
   parameter int HP_W          = DEF_HP_W,
   parameter int LEVEL_NUM     = DEF_LEVEL_NUM,
   parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES,
   parameter int BANNER_FRAMES = DEF_BANNER_FRAMES
) (
   input  logic           clock,
   input  logic           reset,
   game_sequencer_if.slave bus
);
   localparam int LEVEL_W = (LEVEL_NUM > 1) ? clog2(LEVEL_NUM) : 1;
   localparam int CNT_W   =
      clog2(max_int(SERVE_FRAMES, BANNER_FRAMES) + 1);
   localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVEL_NUM - 1);
   localparam logic [HP_W-1:0]    HP_START   = HP_W'(INIT_HP);

   state_e             state_d, state_q;
   result_e            result_d, result_q;
   logic [HP_W-1:0]    hp_d, hp_q;
   logic [LEVEL_W-1:0] level_d, level_q;
   logic               run_d, run_q;
   logic               serve_d, serve_q;
   logic               load_level_d, load_level_q;
   logic               entry;
   logic               sel_banner;
   logic               done;

   assign sel_banner = (state_q == ST_LOST) || (state_q == ST_CLEAR);

   game_sequencer_frame_timer #(
      .SERVE_FRAMES  (SERVE_FRAMES),
      .BANNER_FRAMES (BANNER_FRAMES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .tick       (bus.frame_tick),
      .clr        (entry),
      .sel_banner (sel_banner),
      .done       (done)
   );

   always_comb begin
      state_d  = state_q;
      hp_d     = hp_q;
      level_d  = level_q;
      result_d = result_q;
      unique case (state_q)
         ST_IDLE:
            if (bus.start) begin
               state_d  = ST_LOAD;
               hp_d     = HP_START;
               level_d  = '0;
               result_d = RES_NONE;
            end
         // Ready is ignored while the load request is still in flight.
         ST_LOAD:
            if (bus.level_ready && !load_level_q) state_d = ST_SERVE;
         ST_SERVE:
            if (bus.start || done) state_d = ST_PLAY;
         ST_PLAY:
            if (bus.all_cleared) begin
               state_d = ST_CLEAR;
            end else if (bus.ball_lost) begin
               state_d = ST_LOST;
               hp_d    = (hp_q == '0) ? '0 : hp_q - 1'b1;
            end
         ST_LOST:
            if (hp_q == '0) begin
               state_d  = ST_OVER;
               result_d = RES_LOSE;
            end else if (done) begin
               state_d = ST_SERVE;
            end
         ST_CLEAR:
            if (done) begin
               if (level_q == LAST_LEVEL) begin
                  state_d  = ST_WIN;
                  result_d = RES_WIN;
               end else begin
                  state_d = ST_LOAD;
                  level_d = level_q + 1'b1;
               end
            end
         ST_OVER, ST_WIN:
            if (bus.start) state_d = ST_IDLE;
      endcase
      entry        = (state_d != state_q);
      run_d        = (state_d == ST_SERVE) || (state_d == ST_PLAY);
      serve_d      = (state_q == ST_SERVE) && (state_d == ST_PLAY);
      load_level_d = entry && (state_d == ST_LOAD);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         result_q     <= RES_NONE;
         hp_q         <= '0;
         level_q      <= '0;
         run_q        <= 1'b0;
         serve_q      <= 1'b0;
         load_level_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_q     <= result_d;
         hp_q         <= hp_d;
         level_q      <= level_d;
         run_q        <= run_d;
         serve_q      <= serve_d;
         load_level_q <= load_level_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.result     = result_q;
   assign bus.hp         = hp_q;
   assign bus.level      = level_q;
   assign bus.run        = run_q;
   assign bus.serve      = serve_q;
   assign bus.load_level = load_level_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scenario bench for game_sequencer; expected game facts
// come from a small score model (hp, level, result) kept here.
module tb_game_sequencer;
   localparam int INIT_HP       = 3;
   localparam int HP_W          = 6;
   localparam int LEVEL_NUM     = 4;
   localparam int LEVEL_W       = 2;
   localparam int SERVE_FRAMES  = 60;
   localparam int BANNER_FRAMES = 120;

   localparam int S_IDLE  = 0;
   localparam int S_LOAD  = 1;
   localparam int S_SERVE = 2;
   localparam int S_PLAY  = 3;
   localparam int S_LOST  = 4;
   localparam int S_CLEAR = 5;
   localparam int S_OVER  = 6;
   localparam int S_WIN   = 7;

   logic clock = 1'b0;
   logic reset = 1'b0;

   game_sequencer_if #(.LEVEL_W(LEVEL_W), .HP_W(HP_W)) bus ();

   game_sequencer #(
      .INIT_HP       (INIT_HP),
      .HP_W          (HP_W),
      .LEVEL_NUM     (LEVEL_NUM),
      .SERVE_FRAMES  (SERVE_FRAMES),
      .BANNER_FRAMES (BANNER_FRAMES)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;
   int m_hp = 0;
   int m_level = 0;
   int m_result = 0;

   function automatic logic [15:0] obs();
      return {bus.state, bus.run, bus.serve, bus.load_level,
              bus.level, bus.hp, bus.result};
   endfunction

   function automatic logic [15:0] expv(int st, bit r, bit s, bit l);
      return {st[2:0], r, s, l, m_level[1:0], m_hp[5:0], m_result[1:0]};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic tick(int n, bit noise);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            if (noise) begin
               bus.ball_lost   = 1'($urandom_range(0, 1));
               bus.all_cleared = 1'($urandom_range(0, 1));
            end
            cyc();
         end
         bus.ball_lost   = 1'b0;
         bus.all_cleared = 1'b0;
         bus.frame_tick  = 1'b1;
         cyc();
         bus.frame_tick = 1'b0;
      end
   endtask

   task automatic do_load();
      n_vec++;
      if (obs() !== expv(S_LOAD, 0, 0, 1)) begin
         n_err++;
         $display("FAIL load_pulse: actual %h required %h",
                  obs(), expv(S_LOAD, 0, 0, 1));
      end
      if ($urandom_range(0, 1) == 1) begin
         bus.level_ready = 1'b1;
         cyc();
         n_vec++;
         if (obs() !== expv(S_LOAD, 0, 0, 0)) begin
            n_err++;
            $display("FAIL ready_during_pulse: actual %h required %h",
                     obs(), expv(S_LOAD, 0, 0, 0));
         end
      end else begin
         int d;
         d = $urandom_range(1, 6);
         for (int i = 0; i < d; i++) begin
            bus.frame_tick = 1'($urandom_range(0, 1));
            bus.ball_lost  = 1'($urandom_range(0, 1));
            cyc();
            bus.frame_tick = 1'b0;
            bus.ball_lost  = 1'b0;
            n_vec++;
            if (obs() !== expv(S_LOAD, 0, 0, 0)) begin
               n_err++;
               $display("FAIL load_wait: actual %h required %h",
                        obs(), expv(S_LOAD, 0, 0, 0));
            end
         end
         bus.level_ready = 1'b1;
      end
      cyc();
      bus.level_ready = 1'b0;
      n_vec++;
      if (obs() !== expv(S_SERVE, 1, 0, 0)) begin
         n_err++;
         $display("FAIL load_to_serve: actual %h required %h",
                  obs(), expv(S_SERVE, 1, 0, 0));
      end
   endtask

   task automatic do_serve();
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
         tick(SERVE_FRAMES - 1, 1'b1);
         n_vec++;
         if (obs() !== expv(S_SERVE, 1, 0, 0)) begin
            n_err++;
            $display("FAIL serve_early: actual %h required %h",
                     obs(), expv(S_SERVE, 1, 0, 0));
         end
         tick(1, 1'b1);
         n_vec++;
         if (obs() !== expv(S_SERVE, 1, 0, 0)) begin
            n_err++;
            $display("FAIL serve_count_hit: actual %h required %h",
                     obs(), expv(S_SERVE, 1, 0, 0));
         end
         cyc();
      end else if (mode == 1) begin
         int k;
         k = $urandom_range(1, SERVE_FRAMES - 1);
         tick(k - 1, 1'b1);
         bus.frame_tick = 1'b1;
         bus.start      = 1'b1;
         cyc();
         bus.frame_tick = 1'b0;
         bus.start      = 1'b0;
      end else begin
         tick(SERVE_FRAMES, 1'b1);
         bus.start = 1'b1;
         cyc();
         bus.start = 1'b0;
      end
      n_vec++;
      if (obs() !== expv(S_PLAY, 1, 1, 0)) begin
         n_err++;
         $display("FAIL serve_pulse mode%0d: actual %h required %h",
                  mode, obs(), expv(S_PLAY, 1, 1, 0));
      end
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      n_vec++;
      if (obs() !== expv(S_PLAY, 1, 0, 0)) begin
         n_err++;
         $display("FAIL serve_once: actual %h required %h",
                  obs(), expv(S_PLAY, 1, 0, 0));
      end
   endtask

   task automatic lose_ball();
      tick($urandom_range(0, 5), 1'b0);
      bus.ball_lost = 1'b1;
      cyc();
      bus.ball_lost = 1'b0;
      m_hp = (m_hp > 0) ? m_hp - 1 : 0;
      n_vec++;
      if (obs() !== expv(S_LOST, 0, 0, 0)) begin
         n_err++;
         $display("FAIL loss_enter: actual %h required %h",
                  obs(), expv(S_LOST, 0, 0, 0));
      end
      if (m_hp == 0) begin
         cyc();
         m_result = 2;
         n_vec++;
         if (obs() !== expv(S_OVER, 0, 0, 0)) begin
            n_err++;
            $display("FAIL game_over: actual %h required %h",
                     obs(), expv(S_OVER, 0, 0, 0));
         end
         bus.ball_lost = 1'b1;
         cyc();
         bus.ball_lost = 1'b0;
         n_vec++;
         if (obs() !== expv(S_OVER, 0, 0, 0)) begin
            n_err++;
            $display("FAIL hp_saturate: actual %h required %h",
                     obs(), expv(S_OVER, 0, 0, 0));
         end
      end else begin
         tick(BANNER_FRAMES, 1'b1);
         n_vec++;
         if (obs() !== expv(S_LOST, 0, 0, 0)) begin
            n_err++;
            $display("FAIL lost_banner: actual %h required %h",
                     obs(), expv(S_LOST, 0, 0, 0));
         end
         cyc();
         n_vec++;
         if (obs() !== expv(S_SERVE, 1, 0, 0)) begin
            n_err++;
            $display("FAIL lost_to_serve: actual %h required %h",
                     obs(), expv(S_SERVE, 1, 0, 0));
         end
      end
   endtask

   task automatic clear_level();
      tick(BANNER_FRAMES - 1, 1'b1);
      n_vec++;
      if (obs() !== expv(S_CLEAR, 0, 0, 0)) begin
         n_err++;
         $display("FAIL clear_banner_early: actual %h required %h",
                  obs(), expv(S_CLEAR, 0, 0, 0));
      end
      tick(1, 1'b1);
      cyc();
      if (m_level == LEVEL_NUM - 1) begin
         m_result = 1;
         n_vec++;
         if (obs() !== expv(S_WIN, 0, 0, 0)) begin
            n_err++;
            $display("FAIL win: actual %h required %h",
                     obs(), expv(S_WIN, 0, 0, 0));
         end
      end else begin
         m_level++;
         do_load();
      end
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      m_hp     = INIT_HP;
      m_level  = 0;
      m_result = 0;
      do_load();
   endtask

   task automatic test_reset();
      reset           = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.start       = 1'b0;
      bus.level_ready = 1'b0;
      bus.ball_lost   = 1'b0;
      bus.all_cleared = 1'b0;
      repeat (3) cyc();
      n_vec++;
      if (obs() !== expv(S_IDLE, 0, 0, 0)) begin
         n_err++;
         $display("FAIL reset_state: actual %h required %h",
                  obs(), expv(S_IDLE, 0, 0, 0));
      end
      reset = 1'b1;
      tick(3, 1'b1);
      n_vec++;
      if (obs() !== expv(S_IDLE, 0, 0, 0)) begin
         n_err++;
         $display("FAIL idle_hold: actual %h required %h",
                  obs(), expv(S_IDLE, 0, 0, 0));
      end
   endtask

   task automatic test_losses();
      start_game();
      do_serve();
      for (int i = 0; i < INIT_HP; i++) begin
         lose_ball();
         if (m_hp > 0) do_serve();
      end
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      n_vec++;
      if (obs() !== expv(S_IDLE, 0, 0, 0)) begin
         n_err++;
         $display("FAIL over_to_idle: actual %h required %h",
                  obs(), expv(S_IDLE, 0, 0, 0));
      end
   endtask

   task automatic test_levels();
      start_game();
      for (int lv = 0; lv < LEVEL_NUM; lv++) begin
         do_serve();
         if (lv > 0 && m_hp > 1 && $urandom_range(0, 1) == 1) begin
            lose_ball();
            do_serve();
         end
         tick($urandom_range(0, 4), 1'b0);
         bus.all_cleared = 1'b1;
         bus.ball_lost   = (lv == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         cyc();
         bus.ball_lost = 1'b0;
         n_vec++;
         if (obs() !== expv(S_CLEAR, 0, 0, 0)) begin
            n_err++;
            $display("FAIL clear_enter lv%0d: actual %h required %h",
                     lv, obs(), expv(S_CLEAR, 0, 0, 0));
         end
         repeat ($urandom_range(0, 3)) cyc();
         bus.all_cleared = 1'b0;
         clear_level();
      end
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      n_vec++;
      if (obs() !== expv(S_IDLE, 0, 0, 0)) begin
         n_err++;
         $display("FAIL win_to_idle: actual %h required %h",
                  obs(), expv(S_IDLE, 0, 0, 0));
      end
   endtask

   task automatic test_reset_mid_play();
      start_game();
      do_serve();
      for (int i = 0; i < 6; i++) begin
         bus.frame_tick = ~bus.frame_tick;
         cyc();
      end
      #2;
      reset = 1'b0;
      #1;
      m_hp     = 0;
      m_level  = 0;
      m_result = 0;
      n_vec++;
      if (obs() !== expv(S_IDLE, 0, 0, 0)) begin
         n_err++;
         $display("FAIL async_reset: actual %h required %h",
                  obs(), expv(S_IDLE, 0, 0, 0));
      end
      repeat (2) cyc();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.frame_tick = 1'($urandom_range(0, 1));
         cyc();
         n_vec++;
         if (obs() !== expv(S_IDLE, 0, 0, 0)) begin
            n_err++;
            $display("FAIL post_reset_quiet: actual %h required %h",
                     obs(), expv(S_IDLE, 0, 0, 0));
         end
      end
      bus.frame_tick = 1'b0;
      start_game();
   endtask

   initial begin
      test_reset();
      test_losses();
      test_levels();
      test_reset_mid_play();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
